// File: rtl/flght_pkg.sv
// -----------------------------------------------------------------------------
// flght_pkg
// Shared definitions for the flight PID mixer: FSM state encoding, fixed-point
// widths of the per-axis error path, and the P/D scale constants.
// No ports (package).
// -----------------------------------------------------------------------------
package flght_pkg;

    // Mixer FSM; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAL      = 2'd1,
        ST_RUN      = 2'd2,
        ST_SPINDOWN = 2'd3
    } state_t;

    // Attitude inputs are 16-bit signed.
    localparam int ATT_W   = 16;

    // Saturated error: 10-bit signed, symmetric range.
    localparam int ERR_W   = 10;
    localparam int ERR_MAX = 511;
    localparam int ERR_MIN = -511;

    // P term = (P_MUL * err) >>> P_SHIFT, i.e. 5/8 of the error.
    localparam int P_MUL   = 5;
    localparam int P_SHIFT = 3;

    // D term = sat12((err - prev) * D_COEFF).
    localparam int D_COEFF = 7;
    localparam int D_W     = 12;
    localparam int D_MAX   = 2047;
    localparam int D_MIN   = -2048;

    // Integrator: 16-bit signed, saturating.
    localparam int ACC_W   = 16;
    localparam int ACC_MAX = 32767;
    localparam int ACC_MIN = -32768;

endpackage

// File: rtl/pid_axis.sv
// -----------------------------------------------------------------------------
// pid_axis
// One control axis: saturated error capture (stage 1), D_DEPTH-deep error
// history for the derivative, saturating integrator, and the P/D/I terms
// formed combinationally from the stage-1 registers.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   vld               new sample: capture error, push history, integrate
//   run               integrator enable; integrator held at 0 when low
//   desired, actual   16-bit signed attitude
//   pterm, dterm, iterm  signed terms for the mixer (valid the cycle after vld)
// -----------------------------------------------------------------------------
module pid_axis
    import flght_pkg::*;
#(
    parameter int D_DEPTH = 12,
    parameter int I_SHIFT = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld,
    input  logic                    run,
    input  logic signed [ATT_W-1:0] desired,
    input  logic signed [ATT_W-1:0] actual,
    output logic signed [ERR_W-1:0] pterm,
    output logic signed [D_W-1:0]   dterm,
    output logic signed [ACC_W-1:0] iterm
);

    localparam int PTR_W = (D_DEPTH > 1) ? $clog2(D_DEPTH) : 1;
    localparam int CNT_W = $clog2(D_DEPTH + 1);
    localparam int PW    = ERR_W + 3;   // holds 5 * err
    localparam int DW    = ERR_W + 4;   // holds (err - prev) * 7

    logic signed [ATT_W:0]   diff;
    logic signed [ERR_W-1:0] err_sat;
    logic signed [ACC_W:0]   acc_sum;
    logic signed [ACC_W-1:0] acc_next;

    logic signed [ERR_W-1:0] err_reg;
    logic signed [ERR_W-1:0] prev_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ERR_W-1:0] err_mem [D_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [CNT_W-1:0]        fill_reg;

    logic signed [PW-1:0]    p_scaled;
    logic signed [PW-1:0]    p_shifted;
    logic signed [ERR_W:0]   d_delta;
    logic signed [DW-1:0]    d_scaled;

    // One extra bit so the subtraction itself can never overflow.
    assign diff = (ATT_W+1)'(desired) - (ATT_W+1)'(actual);

    always_comb begin
        err_sat = diff[ERR_W-1:0];
        if (diff > (ATT_W+1)'(ERR_MAX)) begin
            err_sat = ERR_W'(ERR_MAX);
        end else if (diff < (ATT_W+1)'(ERR_MIN)) begin
            err_sat = ERR_W'(ERR_MIN);
        end
    end

    // Integrator saturates instead of wrapping.
    assign acc_sum = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(err_sat);

    always_comb begin
        acc_next = acc_sum[ACC_W-1:0];
        if (acc_sum > (ACC_W+1)'(ACC_MAX)) begin
            acc_next = ACC_W'(ACC_MAX);
        end else if (acc_sum < (ACC_W+1)'(ACC_MIN)) begin
            acc_next = ACC_W'(ACC_MIN);
        end
    end

    // The history slot at wr_ptr holds the sample pushed D_DEPTH vlds ago,
    // but only once the ring has been filled; before that prev reads as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg    <= '0;
            prev_reg   <= '0;
            acc_reg    <= '0;
            wr_ptr_reg <= '0;
            fill_reg   <= '0;
            for (int i = 0; i < D_DEPTH; i++) begin
                err_mem[i] <= '0;
            end
        end else begin
            if (vld) begin
                err_reg             <= err_sat;
                prev_reg            <= (fill_reg == CNT_W'(D_DEPTH)) ? err_mem[wr_ptr_reg] : '0;
                err_mem[wr_ptr_reg] <= err_sat;
                wr_ptr_reg          <= (wr_ptr_reg == PTR_W'(D_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
                if (fill_reg != CNT_W'(D_DEPTH)) begin
                    fill_reg <= fill_reg + CNT_W'(1);
                end
            end
            if (!run) begin
                acc_reg <= '0;
            end else if (vld) begin
                acc_reg <= acc_next;
            end
        end
    end

    // P term: arithmetic shift rounds toward minus infinity.
    assign p_scaled  = PW'(err_reg) * PW'(P_MUL);
    assign p_shifted = p_scaled >>> P_SHIFT;
    assign pterm     = ERR_W'(p_shifted);

    // D term, saturated to 12 bits.
    assign d_delta  = (ERR_W+1)'(err_reg) - (ERR_W+1)'(prev_reg);
    assign d_scaled = DW'(d_delta) * DW'(D_COEFF);

    always_comb begin
        dterm = D_W'(d_scaled);
        if (d_scaled > DW'(D_MAX)) begin
            dterm = D_W'(D_MAX);
        end else if (d_scaled < DW'(D_MIN)) begin
            dterm = D_W'(D_MIN);
        end
    end

    assign iterm = acc_reg >>> I_SHIFT;

endmodule

// File: rtl/flght_pid_mixer.sv
// -----------------------------------------------------------------------------
// flght_pid_mixer
// Quad-rotor attitude PID + motor mixer. Three pid_axis instances (pitch,
// roll, yaw) produce P/D/I terms one cycle after vld; the mixer combines them
// with thrust into four clamped targets, and the FSM slews the registered
// motor speeds toward them the following cycle (2-cycle latency from vld).
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   vld                              new inertial sample
//   arm                              motors enabled
//   inertial_cal                     calibration in progress
//   d_ptch, d_roll, d_yaw            desired attitude, 16-bit signed
//   ptch, roll, yaw                  actual attitude, 16-bit signed
//   thrst                            thrust, 9-bit unsigned
//   frnt_spd, bck_spd, lft_spd, rght_spd  registered motor speeds
//   spd_vld                          one-cycle pulse per RUN/SPINDOWN update
//   state                            current FSM state
// -----------------------------------------------------------------------------
module flght_pid_mixer
    import flght_pkg::*;
#(
    parameter int SPD_W         = 11,
    parameter int CAL_SPEED     = 'h290,
    parameter int MIN_RUN_SPEED = 'h2C0,
    parameter int D_DEPTH       = 12,
    parameter int I_SHIFT       = 6,
    parameter int RAMP_STEP     = 'h20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld,
    input  logic                    arm,
    input  logic                    inertial_cal,
    input  logic signed [ATT_W-1:0] d_ptch,
    input  logic signed [ATT_W-1:0] d_roll,
    input  logic signed [ATT_W-1:0] d_yaw,
    input  logic signed [ATT_W-1:0] ptch,
    input  logic signed [ATT_W-1:0] roll,
    input  logic signed [ATT_W-1:0] yaw,
    input  logic [8:0]              thrst,
    output logic [SPD_W-1:0]        frnt_spd,
    output logic [SPD_W-1:0]        bck_spd,
    output logic [SPD_W-1:0]        lft_spd,
    output logic [SPD_W-1:0]        rght_spd,
    output logic                    spd_vld,
    output logic [1:0]              state
);

    localparam int TW      = SPD_W + 3;          // signed target width
    localparam int SPD_MAX = (1 << SPD_W) - 1;
    localparam int N_AX    = 3;
    localparam int N_MOT   = 4;
    localparam int AX_P    = 0;
    localparam int AX_R    = 1;
    localparam int AX_Y    = 2;
    localparam int M_F     = 0;
    localparam int M_B     = 1;
    localparam int M_L     = 2;
    localparam int M_R     = 3;

    localparam logic [SPD_W-1:0] STEP    = SPD_W'(RAMP_STEP);
    localparam logic [SPD_W-1:0] CAL_SPD = SPD_W'(CAL_SPEED);

    state_t                  state_reg;
    logic                    vld_d1_reg;
    logic                    spd_vld_reg;
    logic [SPD_W-1:0]        spd_reg  [N_MOT];
    logic [SPD_W-1:0]        slew_arr [N_MOT];

    logic signed [ATT_W-1:0] des_arr   [N_AX];
    logic signed [ATT_W-1:0] act_arr   [N_AX];
    logic signed [ERR_W-1:0] pterm_arr [N_AX];
    logic signed [D_W-1:0]   dterm_arr [N_AX];
    logic signed [ACC_W-1:0] iterm_arr [N_AX];
    logic signed [TW-1:0]    sum_arr   [N_AX];
    logic signed [TW-1:0]    tgt_arr   [N_MOT];
    logic signed [TW-1:0]    base;
    logic                    run_en;
    logic                    all_zero;

    assign run_en = (state_reg == ST_RUN);

    assign des_arr[AX_P] = d_ptch;
    assign des_arr[AX_R] = d_roll;
    assign des_arr[AX_Y] = d_yaw;
    assign act_arr[AX_P] = ptch;
    assign act_arr[AX_R] = roll;
    assign act_arr[AX_Y] = yaw;

    // Stage 1 lives inside each axis; the terms are ready the cycle after vld.
    generate
        for (genvar gi = 0; gi < N_AX; gi++) begin : g_axis
            pid_axis #(
                .D_DEPTH (D_DEPTH),
                .I_SHIFT (I_SHIFT)
            ) u_axis (
                .clk     (clk),
                .rst_n   (rst_n),
                .vld     (vld),
                .run     (run_en),
                .desired (des_arr[gi]),
                .actual  (act_arr[gi]),
                .pterm   (pterm_arr[gi]),
                .dterm   (dterm_arr[gi]),
                .iterm   (iterm_arr[gi])
            );

            assign sum_arr[gi] = TW'(pterm_arr[gi]) + TW'(dterm_arr[gi]) + TW'(iterm_arr[gi]);
        end
    endgenerate

    assign base = TW'(MIN_RUN_SPEED) + TW'(thrst);

    // Motor mix: pitch tilts front/back, roll left/right, yaw opposes pairs.
    assign tgt_arr[M_F] = base - sum_arr[AX_P] - sum_arr[AX_Y];
    assign tgt_arr[M_B] = base + sum_arr[AX_P] - sum_arr[AX_Y];
    assign tgt_arr[M_L] = base - sum_arr[AX_R] + sum_arr[AX_Y];
    assign tgt_arr[M_R] = base + sum_arr[AX_R] + sum_arr[AX_Y];

    // Per motor: clamp target, pick goal (0 once disarmed), step toward it.
    generate
        for (genvar gi = 0; gi < N_MOT; gi++) begin : g_motor
            logic [SPD_W-1:0] clamp_val;
            logic [SPD_W-1:0] goal_val;
            logic [SPD_W-1:0] gap_val;
            logic [SPD_W-1:0] slew_val;

            always_comb begin
                clamp_val = tgt_arr[gi][SPD_W-1:0];
                if (tgt_arr[gi][TW-1]) begin
                    clamp_val = '0;
                end else if (tgt_arr[gi] > TW'(SPD_MAX)) begin
                    clamp_val = SPD_W'(SPD_MAX);
                end

                goal_val = (run_en && arm) ? clamp_val : '0;

                if (goal_val >= spd_reg[gi]) begin
                    gap_val  = goal_val - spd_reg[gi];
                    slew_val = (gap_val > STEP) ? spd_reg[gi] + STEP : goal_val;
                end else begin
                    gap_val  = spd_reg[gi] - goal_val;
                    slew_val = (gap_val > STEP) ? spd_reg[gi] - STEP : goal_val;
                end
            end

            assign slew_arr[gi] = slew_val;
        end
    endgenerate

    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < N_MOT; i++) begin
            if (spd_reg[i] != '0) begin
                all_zero = 1'b0;
            end
        end
    end

    // FSM with registered motor speeds. A vld seen in cycle N reaches the
    // axis registers at the end of N; vld_d1_reg then commits the slewed
    // speeds at the end of N+1. Disarming in RUN still commits that update,
    // already steering toward 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            vld_d1_reg  <= 1'b0;
            spd_vld_reg <= 1'b0;
            for (int i = 0; i < N_MOT; i++) begin
                spd_reg[i] <= '0;
            end
        end else begin
            vld_d1_reg  <= vld;
            spd_vld_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    for (int i = 0; i < N_MOT; i++) begin
                        spd_reg[i] <= arm ? CAL_SPD : '0;
                    end
                    if (arm) begin
                        state_reg <= ST_CAL;
                    end
                end
                ST_CAL: begin
                    for (int i = 0; i < N_MOT; i++) begin
                        spd_reg[i] <= CAL_SPD;
                    end
                    if (!arm) begin
                        state_reg <= ST_SPINDOWN;
                    end else if (!inertial_cal) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (vld_d1_reg) begin
                        spd_vld_reg <= 1'b1;
                        for (int i = 0; i < N_MOT; i++) begin
                            spd_reg[i] <= slew_arr[i];
                        end
                    end
                    if (!arm) begin
                        state_reg <= ST_SPINDOWN;
                    end
                end
                ST_SPINDOWN: begin
                    if (vld_d1_reg) begin
                        spd_vld_reg <= 1'b1;
                        for (int i = 0; i < N_MOT; i++) begin
                            spd_reg[i] <= slew_arr[i];
                        end
                    end
                    if (all_zero) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign frnt_spd = spd_reg[M_F];
    assign bck_spd  = spd_reg[M_B];
    assign lft_spd  = spd_reg[M_L];
    assign rght_spd = spd_reg[M_R];
    assign spd_vld  = spd_vld_reg;
    assign state    = state_reg;

endmodule

// File: tb/tb_flght_pid_mixer.sv
// -----------------------------------------------------------------------------
// tb_flght_pid_mixer
// Directed bench for flght_pid_mixer: reset, calibration and ramp-up, P/I
// response to a pitch error, saturation/clamping, spindown, asynchronous
// reset mid-RUN and back-to-back samples. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_flght_pid_mixer;

    logic               clk;
    logic               rst_n;
    logic               vld;
    logic               arm;
    logic               inertial_cal;
    logic signed [15:0] d_ptch, d_roll, d_yaw;
    logic signed [15:0] ptch, roll, yaw;
    logic [8:0]         thrst;
    logic [10:0]        frnt_spd, bck_spd, lft_spd, rght_spd;
    logic               spd_vld;
    logic [1:0]         state;

    int n_cmp = 0;
    int n_bad = 0;

    flght_pid_mixer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld          (vld),
        .arm          (arm),
        .inertial_cal (inertial_cal),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .ptch         (ptch),
        .roll         (roll),
        .yaw          (yaw),
        .thrst        (thrst),
        .frnt_spd     (frnt_spd),
        .bck_spd      (bck_spd),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd),
        .spd_vld      (spd_vld),
        .state        (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            $display("ok   %s = %0d (0x%0h)", tag, got, got);
        end
    endtask

    task automatic check_motors(input string tag, input int f, input int b, input int l, input int r);
        check_val({tag, " front"}, int'(frnt_spd), f);
        check_val({tag, " back"},  int'(bck_spd),  b);
        check_val({tag, " left"},  int'(lft_spd),  l);
        check_val({tag, " right"}, int'(rght_spd), r);
    endtask

    // Called at a falling edge: one-cycle vld, returns two falling edges
    // later, i.e. just after the update that vld produced.
    task automatic pulse_vld();
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int exp_spd;
        rst_n        = 1'b1;
        vld          = 1'b0;
        arm          = 1'b0;
        inertial_cal = 1'b0;
        d_ptch = '0; d_roll = '0; d_yaw = '0;
        ptch   = '0; roll   = '0; yaw   = '0;
        thrst  = '0;

        // ---------------- reset ----------------
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("reset state", int'(state), 0);
        check_motors("reset", 0, 0, 0, 0);
        check_val("reset spd_vld", int'(spd_vld), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- calibration then ramp to 0x3C0 ----------------
        arm = 1'b1;
        inertial_cal = 1'b1;
        @(negedge clk);
        check_val("cal state", int'(state), 1);
        check_motors("cal", 'h290, 'h290, 'h290, 'h290);
        inertial_cal = 1'b0;
        thrst = 9'h100;
        @(negedge clk);
        check_val("run state", int'(state), 2);
        for (int i = 1; i <= 10; i++) begin
            pulse_vld();
            exp_spd = 'h290 + 'h20 * i;
            if (exp_spd > 'h3C0) exp_spd = 'h3C0;
            check_motors($sformatf("ramp%0d", i), exp_spd, exp_spd, exp_spd, exp_spd);
            check_val($sformatf("ramp%0d spd_vld", i), int'(spd_vld), 1);
        end

        // ---------------- spindown from 0x3C0, re-arm ignored ----------------
        arm = 1'b0;
        @(negedge clk);
        check_val("spindown state", int'(state), 3);
        check_val("spindown hold front", int'(frnt_spd), 'h3C0);
        for (int i = 1; i <= 30; i++) begin
            pulse_vld();
            exp_spd = 'h3C0 - 'h20 * i;
            check_motors($sformatf("spin%0d", i), exp_spd, exp_spd, exp_spd, exp_spd);
            check_val($sformatf("spin%0d state", i), int'(state), 3);
            if (i == 12) arm = 1'b1;
            if (i == 20) arm = 1'b0;
        end
        @(negedge clk);
        check_val("spindown done state", int'(state), 0);

        // ---------------- re-arm, ramp, then pitch error +40 ----------------
        arm = 1'b1;
        inertial_cal = 1'b1;
        @(negedge clk);
        check_val("rearm cal state", int'(state), 1);
        inertial_cal = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 10; i++) pulse_vld();
        check_motors("rearm ramp", 'h3C0, 'h3C0, 'h3C0, 'h3C0);
        d_ptch = 16'sd40;
        for (int k = 1; k <= 64; k++) begin
            pulse_vld();
            // k=1: P 25 + D 280 + I 0 -> targets 655/1265, one 0x20 step
            if (k == 1)  check_motors("pitch k1", 'h3A0, 'h3E0, 'h3C0, 'h3C0);
            // k=63: acc 2520 -> I 39, sum 64
            if (k == 63) check_motors("pitch k63", 896, 1024, 960, 960);
            // k=64: acc 2560 -> I 40, sum 65
            if (k == 64) check_motors("pitch k64", 895, 1025, 960, 960);
        end

        // ---------------- asynchronous reset mid-RUN ----------------
        #3 rst_n = 1'b0;
        #1;
        check_val("async reset state", int'(state), 0);
        check_motors("async reset", 0, 0, 0, 0);
        check_val("async reset spd_vld", int'(spd_vld), 0);
        arm = 1'b0;
        d_ptch = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- saturation and clamping ----------------
        arm = 1'b1;
        inertial_cal = 1'b1;
        @(negedge clk);
        check_val("sat cal state", int'(state), 1);
        inertial_cal = 1'b0;
        @(negedge clk);
        check_val("sat run state", int'(state), 2);
        thrst  = 9'd511;
        d_ptch = 16'sd1000;
        d_roll = 16'sd1000;
        d_yaw  = 16'sd1000;
        for (int k = 1; k <= 70; k++) begin
            pulse_vld();
            // err 511: sum 319+2047+7 -> front<0, right>0x7FF; step from 0x290
            if (k == 1)  check_motors("sat k1", 'h270, 'h2B0, 'h2B0, 'h2B0);
            // acc saturated: sum 830, base 1215 -> front 0, right 0x7FF
            if (k == 70) check_motors("sat k70", 0, 1215, 1215, 'h7FF);
        end

        // ---------------- back-to-back vld ----------------
        vld = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check_val($sformatf("b2b cycle%0d spd_vld", c), int'(spd_vld), (c >= 2 && c <= 5) ? 1 : 0);
            if (c == 4) vld = 1'b0;
        end
        check_motors("b2b steady", 0, 1215, 1215, 'h7FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
